func_check_sink: RTL
====================

FUNC_CHECK_SINK -- requirements
Module: func_check_sink

Interface
REQ-001 Parameter TRUTH_TABLE, 16'h6996, golden output: bit i is the expected Y for {A,B,C,D}==i. The default is 4-input odd parity.
REQ-002 Parameter ERR_W, 5, width of the error counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins (or restarts) a checking sweep.
REQ-006 in_valid  in  1  qualifies in_vec and the three y_* samples this cycle.
REQ-007 in_vec  in  4  applied stimulus {A,B,C,D}, with A=bit3.
REQ-008 y_df, y_1mux, y_2mux  in  1 each  responses of the dataflow, one-mux and two-mux implementations.
REQ-009 busy  out  1  high in RUN.
REQ-010 done  out  1  high in DONE.
REQ-011 pass  out  1  done && err_cnt==0.
REQ-012 err_cnt  out  ERR_W  count of failing samples, saturating.
REQ-013 err_map  out  3  sticky per-implementation fail flags: bit0 df, bit1 1mux, bit2 2mux.
REQ-014 first_fail_vld / first_fail_vec  out  1 / 4  the first failing in_vec of the sweep is captured and valid.
REQ-015 cov  out  16  bit i set once vector i has been checked this sweep.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
- IDLE --start--> RUN.
- RUN --cov becomes 16'hFFFF--> DONE.
- DONE --start--> RUN.
- RUN --start--> RUN (restart).
REQ-017 Entering RUN on a start pulse clears err_cnt, err_map, first_fail_vld, first_fail_vec and cov on that same edge.
REQ-018 A sample is accepted only in RUN with in_valid=1 and start=0; a sample presented with start=1 is discarded.
REQ-019 in_valid in IDLE or DONE is ignored, and all outputs hold.
REQ-020 Each y_* is compared against TRUTH_TABLE[in_vec]; a sample fails if any of the three mismatch.
REQ-021 Results of an accepted sample are visible on the outputs on the next rising edge (latency 1); there is no other pipelining.
REQ-022 A failing sample increments err_cnt by exactly 1 regardless of how many implementations mismatch; err_cnt saturates at 2^ERR_W-1.
REQ-023 A failing sample ORs the mismatching implementation bits into err_map.
REQ-024 On the first failing sample of a sweep, first_fail_vec<=in_vec and first_fail_vld<=1; later failures do not overwrite it.
REQ-025 Each accepted sample sets cov[in_vec]. Repeated vectors are checked and counted again but do not change cov.
REQ-026 The transition to DONE occurs on the same edge that sets the last missing cov bit, so done rises one cycle after the completing sample.
REQ-027 In DONE, all result outputs hold until the next start.

Reset
REQ-028 rst_n low asynchronously forces IDLE and zeroes busy, done, pass, err_cnt, err_map, first_fail_vld, first_fail_vec and cov, including mid-sweep.
REQ-029 After rst_n deasserts, the block remains in IDLE until a start pulse.

Structure
REQ-030 Package func_check_pkg holds the state enum, ERR_W default, and TRUTH_TABLE default constant.
REQ-031 One sub-module, func_golden, implements the combinational TRUTH_TABLE lookup (in_vec -> expected Y); the top module owns the FSM and all registers.

Verification
REQ-032 Reset, start, then vectors 0..15 one per cycle with correct parity outputs -> done=1 one cycle after vector 15; pass=1, err_cnt=0, err_map=0, cov=16'hFFFF.
REQ-033 Same sweep with y_1mux inverted at vector 5 only -> err_cnt=1, err_map=3'b010, first_fail_vec=4'd5, first_fail_vld=1, pass=0.
REQ-034 Same sweep with all three y_* wrong at vector 9 and y_2mux wrong at vector 12 -> err_cnt=2, err_map=3'b111, first_fail_vec=4'd9.
REQ-035 40 failing samples of vector 0 -> err_cnt=31, cov=16'h0001, busy=1, done=0.
REQ-036 Half sweep (vectors 0..7), then start asserted together with in_valid for vector 8 -> next cycle cov=0 and err_cnt=0; vector 8 is not recorded.
REQ-037 rst_n pulsed low mid-sweep after one failure -> all outputs are 0 immediately, with no clock edge required; busy stays 0 until start.

Source files
------------

// File: rtl/func_check_pkg.sv
// Shared types and default constants for the functional checking sink.
// The default truth table is 4-input odd parity, indexed by {A,B,C,D}.
package func_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          ERR_W_DEF       = 5;
  localparam logic [15:0] TRUTH_TABLE_DEF = 16'h6996;

endpackage : func_check_pkg

// File: rtl/func_golden.sv
// Combinational golden model: looks up the expected Y for a 4-bit {A,B,C,D} vector.
module func_golden
  import func_check_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TRUTH_TABLE_DEF
) (
  input  logic [3:0] in_vec,
  output logic       y_exp
);

  assign y_exp = TRUTH_TABLE[in_vec];

endmodule : func_golden

// File: rtl/func_check_sink.sv
// Compares three implementations of a 4-input function against a golden table
// over a full sweep of all 16 vectors, tracking errors, coverage and the first failure.
module func_check_sink
  import func_check_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TRUTH_TABLE_DEF,
  parameter int          ERR_W       = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_vec,
  input  logic             y_df,
  input  logic             y_1mux,
  input  logic             y_2mux,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       err_map,
  output logic             first_fail_vld,
  output logic [3:0]       first_fail_vec,
  output logic [15:0]      cov
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
  logic [2:0]       errMap_q, errMap_d;
  logic             ffVld_q, ffVld_d;
  logic [3:0]       ffVec_q, ffVec_d;
  logic [15:0]      cov_q, cov_d;

  logic             yExp;
  logic             acceptSample;
  logic [2:0]       mismatch;
  logic [15:0]      covNext;

  func_golden #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_golden (
    .in_vec(in_vec),
    .y_exp (yExp)
  );

  assign acceptSample = (state_q == RUN) && in_valid && !start;
  assign mismatch     = {y_2mux ^ yExp, y_1mux ^ yExp, y_df ^ yExp};
  assign covNext      = cov_q | (16'd1 << in_vec);

  // A start pulse wins over everything and restarts from a clean slate;
  // otherwise only accepted samples in RUN change state, so IDLE/DONE hold.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    errCnt_d = errCnt_q;
    errMap_d = errMap_q;
    ffVld_d  = ffVld_q;
    ffVec_d  = ffVec_q;
    cov_d    = cov_q;

    if (start) begin
      state_d  = RUN;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      errCnt_d = '0;
      errMap_d = '0;
      ffVld_d  = 1'b0;
      ffVec_d  = '0;
      cov_d    = '0;
    end else if (acceptSample) begin
      if (mismatch != 3'b000) begin
        errCnt_d = (errCnt_q == ERR_MAX) ? errCnt_q : errCnt_q + ERR_W'(1);
        errMap_d = errMap_q | mismatch;
        if (!ffVld_q) begin
          ffVld_d = 1'b1;
          ffVec_d = in_vec;
        end
      end
      cov_d = covNext;
      // Completing coverage ends the sweep on this same edge.
      if (covNext == 16'hFFFF) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (errCnt_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      errCnt_q <= '0;
      errMap_q <= '0;
      ffVld_q  <= 1'b0;
      ffVec_q  <= '0;
      cov_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      errCnt_q <= errCnt_d;
      errMap_q <= errMap_d;
      ffVld_q  <= ffVld_d;
      ffVec_q  <= ffVec_d;
      cov_q    <= cov_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = errCnt_q;
  assign err_map        = errMap_q;
  assign first_fail_vld = ffVld_q;
  assign first_fail_vec = ffVec_q;
  assign cov            = cov_q;

endmodule : func_check_sink
